// File: rtl/ctrl_exposure_fsm_pkg.sv
// Shared types and helpers for the exposure capture sequencer and the
// exposure-time control register (both use the same clamp limits).
package ctrl_exposure_fsm_pkg;

  localparam int EXP_MIN_DEF = 2;
  localparam int EXP_MAX_DEF = 30;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EXPOSE,
    S_R1_SETUP,
    S_R1_CONV,
    S_R1_HOLD,
    S_GAP,
    S_R2_SETUP,
    S_R2_CONV,
    S_R2_HOLD,
    S_DONE
  } state_t;

  typedef struct packed {
    logic erase;
    logic expose;
    logic nre_1;
    logic nre_2;
    logic adc;
    logic busy;
    logic done;
  } outs_t;

  typedef struct packed {
    state_t     state;
    logic [4:0] exp_t;
  } dbg_t;

  function automatic int cnt_width(input int exp_max, input int tpm, input int adc_cycles);
    int w;
    int wa;
    w  = $clog2(exp_max * tpm);
    wa = $clog2(adc_cycles);
    if (wa > w) w = wa;
    if (w < 1) w = 1;
    return w;
  endfunction

  function automatic logic [4:0] clamp_exp(input logic [4:0] t, input int lo, input int hi);
    if (int'(t) < lo) return 5'(lo);
    if (int'(t) > hi) return 5'(hi);
    return t;
  endfunction

  // Moore output values for each state.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '{erase: 1'b0, expose: 1'b0, nre_1: 1'b1, nre_2: 1'b1,
          adc: 1'b0, busy: 1'b1, done: 1'b0};
    case (s)
      S_IDLE:     begin o.erase = 1'b1; o.busy = 1'b0; end
      S_EXPOSE:   o.expose = 1'b1;
      S_R1_SETUP: o.nre_1 = 1'b0;
      S_R1_CONV:  begin o.nre_1 = 1'b0; o.adc = 1'b1; end
      S_R1_HOLD:  o.nre_1 = 1'b0;
      S_GAP:      ;
      S_R2_SETUP: o.nre_2 = 1'b0;
      S_R2_CONV:  begin o.nre_2 = 1'b0; o.adc = 1'b1; end
      S_R2_HOLD:  o.nre_2 = 1'b0;
      S_DONE:     begin o.done = 1'b1; o.busy = 1'b0; end
      default:    begin o.erase = 1'b1; o.busy = 1'b0; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_exposure_fsm_counter.sv
// Loadable down-counter used for exposure duration and ADC conversion timing.
module exp_down_counter #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ctrl_exposure_fsm.sv
// Capture sequencer: erase, expose for the latched time, then read two rows
// through the shared ADC. All strobes are registered Moore outputs.
module ctrl_exposure_fsm
  import ctrl_exposure_fsm_pkg::*;
#(
  parameter int TICKS_PER_MS = 1,
  parameter int ADC_CYCLES   = 2,
  parameter int EXP_MIN      = EXP_MIN_DEF,
  parameter int EXP_MAX      = EXP_MAX_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic [4:0] Exp_time,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Busy,
  output logic       Done,
  output dbg_t       o_dbg
);

  localparam int CW = cnt_width(EXP_MAX, TICKS_PER_MS, ADC_CYCLES);
  localparam logic [CW-1:0] TPM_C    = CW'(TICKS_PER_MS);
  localparam logic [CW-1:0] ADC_LOAD = CW'(ADC_CYCLES - 1);

  state_t        r_state;
  outs_t         r_outs;
  logic [4:0]    r_exp_t;

  state_t        w_next;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_en;
  logic          w_zero;
  logic [4:0]    w_t;
  logic [CW-1:0] w_exp_load;

  assign w_t        = clamp_exp(Exp_time, EXP_MIN, EXP_MAX);
  assign w_exp_load = CW'(w_t) * TPM_C - CW'(1);

  exp_down_counter #(.W(CW)) u_cnt (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  // Counted states load on the transition in and leave once the count is 0.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Init) begin
          w_next     = S_EXPOSE;
          w_load     = 1'b1;
          w_load_val = w_exp_load;
        end
      end
      S_EXPOSE: begin
        if (w_zero) w_next = S_R1_SETUP;
        else        w_en   = 1'b1;
      end
      S_R1_SETUP: begin
        w_next     = S_R1_CONV;
        w_load     = 1'b1;
        w_load_val = ADC_LOAD;
      end
      S_R1_CONV: begin
        if (w_zero) w_next = S_R1_HOLD;
        else        w_en   = 1'b1;
      end
      S_R1_HOLD:  w_next = S_GAP;
      S_GAP:      w_next = S_R2_SETUP;
      S_R2_SETUP: begin
        w_next     = S_R2_CONV;
        w_load     = 1'b1;
        w_load_val = ADC_LOAD;
      end
      S_R2_CONV: begin
        if (w_zero) w_next = S_R2_HOLD;
        else        w_en   = 1'b1;
      end
      S_R2_HOLD:  w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_outs  <= decode(S_IDLE);
      r_exp_t <= '0;
    end else begin
      r_state <= w_next;
      r_outs  <= decode(w_next);
      if ((r_state == S_IDLE) && Init) r_exp_t <= w_t;
    end
  end

  assign Erase  = r_outs.erase;
  assign Expose = r_outs.expose;
  assign NRE_1  = r_outs.nre_1;
  assign NRE_2  = r_outs.nre_2;
  assign ADC    = r_outs.adc;
  assign Busy   = r_outs.busy;
  assign Done   = r_outs.done;

  assign o_dbg.state = r_state;
  assign o_dbg.exp_t = r_exp_t;

endmodule
